// File: rtl/clock_alarm_core.sv
// clock_alarm_core: Avalon-MM time-of-day clock with alarm and prescaled tick input.
// Define CLOCK_ALARM_BCD_READ_EN to read time/alarm fields as packed BCD.
module clock_alarm_core #(
  parameter int unsigned TICKS_PER_SEC = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [2:0]  address,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  output logic        irq
);
  localparam logic [15:0] PRE_MAX = 16'(TICKS_PER_SEC - 1);
  logic [5:0] sec_q, sec_d, min_q, min_d, alm_min_q, alm_min_d;
  logic [4:0] hour_q, hour_d, alm_hour_q, alm_hour_d;
  logic [3:0] ctrl_q, ctrl_d;
  logic fired_q, fired_d, secf_q, secf_d;
  logic [15:0] pre_q, pre_d, rdata_q, rdata_d;
  logic wr, lt60, lt24, adv, sec_wrap, min_wrap, alarm_hit;
  logic [5:0] sec_inc, min_inc;
  logic [4:0] hour_inc;
`ifdef CLOCK_ALARM_BCD_READ_EN
  function automatic logic [15:0] fmt(input logic [5:0] v);
    logic [3:0] t;
    t = v >= 6'd50 ? 4'd5 : v >= 6'd40 ? 4'd4 : v >= 6'd30 ? 4'd3 :
        v >= 6'd20 ? 4'd2 : v >= 6'd10 ? 4'd1 : 4'd0;
    return {8'd0, t, 4'(v - ({2'b0, t} * 6'd10))};
  endfunction
`else
  function automatic logic [15:0] fmt(input logic [5:0] v);
    return {10'd0, v};
  endfunction
`endif
  always_comb begin
    wr = chipselect & ~write_n;
    lt60 = writedata < 16'd60;
    lt24 = writedata < 16'd24;
    adv = ctrl_q[0] & tick & (pre_q == PRE_MAX);
    sec_wrap = sec_q == 6'd59;
    min_wrap = min_q == 6'd59;
    sec_inc = sec_wrap ? 6'd0 : sec_q + 6'd1;
    min_inc = sec_wrap ? (min_wrap ? 6'd0 : min_q + 6'd1) : min_q;
    hour_inc = (sec_wrap & min_wrap) ? (hour_q == 5'd23 ? 5'd0 : hour_q + 5'd1) : hour_q;
    // only the counting path can fire the alarm; register writes never do
    alarm_hit = adv & ctrl_q[1] & (sec_inc == 6'd0) & (min_inc == alm_min_q) & (hour_inc == alm_hour_q);
    sec_d = (wr && address == 3'd2 && lt60) ? writedata[5:0] : adv ? sec_inc : sec_q;
    min_d = (wr && address == 3'd3 && lt60) ? writedata[5:0] : adv ? min_inc : min_q;
    hour_d = (wr && address == 3'd4 && lt24) ? writedata[4:0] : adv ? hour_inc : hour_q;
    alm_min_d = (wr && address == 3'd5 && lt60) ? writedata[5:0] : alm_min_q;
    alm_hour_d = (wr && address == 3'd6 && lt24) ? writedata[4:0] : alm_hour_q;
    ctrl_d = (wr && address == 3'd1) ? writedata[3:0] : ctrl_q;
    pre_d = (wr && address == 3'd2 && lt60) ? 16'd0 :
            (ctrl_q[0] & tick) ? (adv ? 16'd0 : pre_q + 16'd1) : pre_q;
    fired_d = alarm_hit | (fired_q & ~(wr && address == 3'd0 && writedata[0]));
    secf_d = adv | (secf_q & ~(wr && address == 3'd0 && writedata[1]));
    rdata_d = '0;
    case (address)
      3'd0: rdata_d = {14'd0, secf_q, fired_q};
      3'd1: rdata_d = {12'd0, ctrl_q};
      3'd2: rdata_d = fmt(sec_q);
      3'd3: rdata_d = fmt(min_q);
      3'd4: rdata_d = fmt({1'b0, hour_q});
      3'd5: rdata_d = fmt(alm_min_q);
      3'd6: rdata_d = fmt({1'b0, alm_hour_q});
      default: rdata_d = pre_q;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sec_q <= '0;
      min_q <= '0;
      hour_q <= '0;
      alm_min_q <= '0;
      alm_hour_q <= '0;
      ctrl_q <= '0;
      fired_q <= 1'b0;
      secf_q <= 1'b0;
      pre_q <= '0;
      rdata_q <= '0;
    end else begin
      sec_q <= sec_d;
      min_q <= min_d;
      hour_q <= hour_d;
      alm_min_q <= alm_min_d;
      alm_hour_q <= alm_hour_d;
      ctrl_q <= ctrl_d;
      fired_q <= fired_d;
      secf_q <= secf_d;
      pre_q <= pre_d;
      rdata_q <= rdata_d;
    end
  end
  assign readdata = rdata_q;
  assign irq = (fired_q & ctrl_q[2]) | (secf_q & ctrl_q[3]);
endmodule

// File: tb/tb_clock_alarm_core.sv
// tb_clock_alarm_core: directed scoreboard bench for clock_alarm_core with TICKS_PER_SEC=4.
module tb_clock_alarm_core;
  logic clk = 0, reset_n = 0, tick = 0, chipselect = 0, write_n = 1;
  logic [2:0] address = 0;
  logic [15:0] writedata = 0, readdata;
  logic irq;
  logic rd_v = 0, rd_v_q = 0, irq_v = 0;
  typedef struct {string name; logic [15:0] exp; bit is_irq;} chk_t;
  chk_t sb[$];
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  clock_alarm_core #(.TICKS_PER_SEC(4)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .chipselect(chipselect), .write_n(write_n),
    .address(address), .writedata(writedata), .readdata(readdata), .irq(irq)
  );
  function automatic logic [15:0] ex(input int v);
`ifdef CLOCK_ALARM_BCD_READ_EN
    return 16'(((v / 10) << 4) | (v % 10));
`else
    return 16'(v);
`endif
  endfunction
  task automatic check(input bit is_irq);
    chk_t c;
    logic [15:0] act;
    act = is_irq ? {15'd0, irq} : readdata;
    total++;
    if (sb.size() == 0) $display("FAIL scoreboard_underflow: got %h with nothing expected", act);
    else begin
      c = sb.pop_front();
      if (c.is_irq != is_irq || act !== c.exp) $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
      else passed++;
    end
  endtask
  always @(posedge clk) rd_v_q <= rd_v;
  always @(negedge clk) begin
    if (rd_v_q) check(1'b0);
    if (irq_v) check(1'b1);
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1; write_n = 0; address = a; writedata = d;
    cyc(1);
    chipselect = 0; write_n = 1;
  endtask
  task automatic rd(input logic [2:0] a, input logic [15:0] e, input string nm);
    chk_t c;
    c.name = nm; c.exp = e; c.is_irq = 0;
    sb.push_back(c);
    address = a; rd_v = 1;
    cyc(1);
    rd_v = 0;
    cyc(1);
  endtask
  task automatic irq_chk(input logic e, input string nm);
    chk_t c;
    c.name = nm; c.exp = {15'd0, e}; c.is_irq = 1;
    sb.push_back(c);
    irq_v = 1;
    cyc(1);
    irq_v = 0;
  endtask
  task automatic tk(input int n);
    tick = 1;
    cyc(n);
    tick = 0;
  endtask
  task automatic all_zero(input string nm);
    for (int i = 0; i < 8; i++) rd(3'(i), 16'd0, nm);
    irq_chk(1'b0, {nm, "_irq"});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    cyc(2);
    reset_n = 1;
    all_zero("reset");
    wr(7, 16'd5);
    rd(7, 16'd0, "prescale_ro");
    wr(1, 16'hFFF0);
    rd(1, 16'd0, "ctrl_unused_bits");
    wr(1, 16'd1);
    tk(2);
    rd(7, 16'd2, "prescale_mid");
    tk(2);
    rd(2, ex(1), "sec_after_4_ticks");
    rd(0, 16'd2, "sec_flag_set");
    rd(7, 16'd0, "prescale_wrap");
    irq_chk(1'b0, "irq_sec_masked");
    wr(1, 16'd9);
    irq_chk(1'b1, "irq_sec_flag");
    wr(0, 16'd2);
    irq_chk(1'b0, "irq_sec_cleared");
    wr(1, 16'd0);
    wr(4, 16'd23); wr(3, 16'd59); wr(2, 16'd59);
    wr(1, 16'd1);
    tk(3);
    rd(2, ex(59), "sec_before_rollover");
    tk(1);
    rd(2, ex(0), "rollover_sec");
    rd(3, ex(0), "rollover_min");
    rd(4, ex(0), "rollover_hour");
    rd(0, 16'd2, "rollover_status");
    wr(0, 16'd3);
    wr(1, 16'd0);
    wr(6, 16'd7); wr(5, 16'd30); wr(4, 16'd7); wr(3, 16'd29); wr(2, 16'd59);
    wr(1, 16'd7);
    tk(4);
    rd(0, 16'd3, "alarm_fired");
    rd(3, ex(30), "alarm_min_carry");
    irq_chk(1'b1, "irq_alarm");
    wr(0, 16'd1);
    irq_chk(1'b0, "irq_alarm_cleared");
    rd(0, 16'd2, "status_after_w1c");
    wr(0, 16'd3);
    wr(1, 16'd6);
    wr(2, 16'd0);
    rd(0, 16'd0, "direct_write_no_alarm");
    wr(3, 16'd29); wr(2, 16'd59); wr(1, 16'd7);
    tk(4);
    rd(0, 16'd3, "alarm_refire");
    wr(1, 16'd6); wr(3, 16'd29); wr(2, 16'd59); wr(1, 16'd7);
    tk(3);
    tick = 1; chipselect = 1; write_n = 0; address = 0; writedata = 16'd1;
    cyc(1);
    tick = 0; chipselect = 0; write_n = 1;
    rd(0, 16'd3, "set_beats_w1c");
    wr(1, 16'd5);
    rd(0, 16'd3, "alarm_en_clear_keeps");
    irq_chk(1'b1, "irq_after_alarm_en_clear");
    wr(1, 16'd0); wr(0, 16'd3);
    rd(0, 16'd0, "status_cleared");
    wr(2, 16'd60);
    rd(2, ex(0), "sec_60_ignored");
    wr(2, 16'd42);
    rd(2, ex(42), "sec_42");
    wr(4, 16'd24);
    rd(4, ex(7), "hour_24_ignored");
    wr(5, 16'd60);
    rd(5, ex(30), "alm_min_60_ignored");
    rd(6, ex(7), "alm_hour");
    wr(1, 16'd1);
    tk(2);
    rd(7, 16'd2, "prescale_before_sec_write");
    wr(2, 16'd10);
    rd(7, 16'd0, "sec_write_clears_prescale");
    wr(1, 16'd1);
    tk(3);
    wr(1, 16'd0);
    tk(10);
    rd(7, 16'd3, "stopped_prescale");
    rd(2, ex(10), "stopped_sec");
    rd(3, ex(30), "stopped_min");
    wr(1, 16'd1);
    tk(1);
    reset_n = 0; tick = 1; chipselect = 1; write_n = 0; address = 1; writedata = 16'hF;
    cyc(1);
    reset_n = 1; tick = 0; chipselect = 0; write_n = 1;
    all_zero("midcount_reset");
    cyc(3);
    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_leftover: got %0d pending expected 0", sb.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
